// File: rtl/sid_note_pkg.sv
// sid_note_pkg: shared types and defaults for the SID V1 note scheduler.
package sid_note_pkg;

    localparam int DEF_DEPTH     = 8;
    localparam int DEF_REL_TICKS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        GATE_ON = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Gate bit is not stored: the scheduler owns it.
    typedef struct packed {
        logic [15:0] freq;
        logic [6:0]  wave;
        logic [7:0]  dur;
    } note_t;

endpackage

// File: rtl/sid_note_fifo.sv
// sid_note_fifo: single-clock note FIFO with flush; head entry is visible
// combinationally so the scheduler can consume it in its LOAD cycle.
module sid_note_fifo
    import sid_note_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  note_t         i_data,
    output note_t         o_head,
    output logic [LW-1:0] o_level,
    output logic          o_full
);

    note_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_level  <= r_level + LW'(i_push) - LW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(DEPTH));

endmodule

// File: rtl/sid_note_scheduler.sv
// sid_note_scheduler: plays queued notes on SID V1 (gate, hold, release gap).
// Define SID_NOTE_REST_EN to treat freq==0 entries as silent rests.
module sid_note_scheduler
    import sid_note_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int REL_TICKS = DEF_REL_TICKS,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_enable,
    input  logic          i_flush,
    input  logic          i_push_valid,
    output logic          o_push_ready,
    input  logic [15:0]   i_push_freq,
    input  logic [7:0]    i_push_wave,
    input  logic [7:0]    i_push_dur,
    output logic [15:0]   o_frequency,
    output logic [7:0]    o_waveform,
    output logic          o_busy,
    output logic [LW-1:0] o_level
);

    state_t      r_state;
    logic [15:0] r_freq;
    logic [6:0]  r_wave;
    logic        r_gate;
    logic [8:0]  r_dur_cnt;
    logic [7:0]  r_rel_cnt;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_rest;
    logic        w_start;
    logic        w_unused_gate;
    note_t       w_head;
    note_t       w_entry;

    assign w_entry       = '{freq: i_push_freq, wave: i_push_wave[7:1], dur: i_push_dur};
    assign w_unused_gate = i_push_wave[0];
    assign w_push        = i_push_valid && !w_full && !i_flush;
    assign w_pop         = (r_state == LOAD) && !i_flush;
    assign w_start       = i_enable && (o_level != '0);

`ifdef SID_NOTE_REST_EN
    assign w_rest = (w_head.freq == 16'd0);
`else
    assign w_rest = 1'b0;
`endif

    sid_note_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_level (o_level),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_freq    <= '0;
            r_wave    <= '0;
            r_gate    <= 1'b0;
            r_dur_cnt <= '0;
            r_rel_cnt <= '0;
        end else if (i_flush) begin
            r_state   <= IDLE;
            r_gate    <= 1'b0;
            r_dur_cnt <= '0;
            r_rel_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= w_start ? LOAD : IDLE;
                LOAD: begin
                    // A rest keeps the previous pitch/timbre and stays silent.
                    if (!w_rest) begin
                        r_freq <= w_head.freq;
                        r_wave <= w_head.wave;
                    end
                    r_gate    <= !w_rest;
                    r_dur_cnt <= {w_head.dur == 8'd0, w_head.dur};
                    r_state   <= GATE_ON;
                end
                GATE_ON: if (i_tick) begin
                    r_dur_cnt <= r_dur_cnt - 9'd1;
                    if (r_dur_cnt == 9'd1) begin
                        r_state   <= RELEASE;
                        r_gate    <= 1'b0;
                        r_rel_cnt <= 8'(REL_TICKS);
                    end
                end
                RELEASE: if (i_tick) begin
                    r_rel_cnt <= r_rel_cnt - 8'd1;
                    if (r_rel_cnt == 8'd1)
                        r_state <= w_start ? LOAD : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_frequency  = r_freq;
    assign o_waveform   = {r_wave, r_gate};
    assign o_busy       = (r_state != IDLE);
    assign o_push_ready = !w_full;

endmodule

// File: tb/tb_sid_note_scheduler.sv
// tb_sid_note_scheduler: vector table plus directed multi-cycle sequences.
module tb_sid_note_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_tick = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_push_valid = 1'b0;
    logic        o_push_ready;
    logic [15:0] i_push_freq = '0;
    logic [7:0]  i_push_wave = '0;
    logic [7:0]  i_push_dur = '0;
    logic [15:0] o_frequency;
    logic [7:0]  o_waveform;
    logic        o_busy;
    logic [3:0]  o_level;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit auto_tick = 0;

    sid_note_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (i_tick),
        .i_enable     (i_enable),
        .i_flush      (i_flush),
        .i_push_valid (i_push_valid),
        .o_push_ready (o_push_ready),
        .i_push_freq  (i_push_freq),
        .i_push_wave  (i_push_wave),
        .i_push_dur   (i_push_dur),
        .o_frequency  (o_frequency),
        .o_waveform   (o_waveform),
        .o_busy       (o_busy),
        .o_level      (o_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [15:0] pf;
        logic [7:0]  pw;
        logic [7:0]  pd;
        logic        tk;
        logic        en;
        logic        fl;
        logic [15:0] ef;
        logic [7:0]  ew;
        logic        eb;
        logic [3:0]  el;
        logic        er;
    } vec_t;

    vec_t tv[23];

    function automatic vec_t mk(logic pv, logic [15:0] pf, logic [7:0] pw, logic [7:0] pd,
                                logic tk, logic en, logic fl, logic [15:0] ef, logic [7:0] ew,
                                logic eb, logic [3:0] el, logic er);
        vec_t v;
        v = '{pv, pf, pw, pd, tk, en, fl, ef, ew, eb, el, er};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_tick)
            i_tick = (cyc % 16 == 0);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        auto_tick = 0;
        {i_tick, i_enable, i_flush, i_push_valid} = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] f, input logic [7:0] w, input logic [7:0] d);
        i_push_valid = 1'b1;
        i_push_freq  = f;
        i_push_wave  = w;
        i_push_dur   = d;
        step();
        i_push_valid = 1'b0;
    endtask

    task automatic wait_gate(input int idx);
        for (int c = 0; c < 10 && !o_waveform[0]; c++)
            step();
        check("gate_rise", idx, o_waveform[0], 1);
    endtask

    // Counts ticks seen with the gate high, then ticks in the release gap until idle.
    task automatic measure(input int max, input int idx, output int g, output int r);
        bit seen, done, pg, pb, t;
        seen = 0;
        done = 0;
        g = 0;
        r = 0;
        for (int c = 0; c < max && !done; c++) begin
            pg = o_waveform[0];
            pb = o_busy;
            t  = i_tick;
            step();
            if (pg)
                seen = 1;
            if (t && pg)
                g++;
            else if (t && pb && seen)
                r++;
            if (seen && !o_busy)
                done = 1;
        end
        check("measure_done", idx, done, 1);
    endtask

    initial begin
        int g, r, k, viol, gap, rises;
        logic [15:0] rf [2];
        bit pg;

        tv[0]  = mk(0, 16'h0000, 8'h00, 8'd0, 0, 1, 0, 16'h0000, 8'h00, 0, 4'd0, 1);
        tv[1]  = mk(1, 16'h1234, 8'h40, 8'd2, 0, 1, 0, 16'h0000, 8'h00, 0, 4'd1, 1);
        tv[2]  = mk(0, 16'h0000, 8'h00, 8'd0, 0, 1, 0, 16'h0000, 8'h00, 1, 4'd1, 1);
        tv[3]  = mk(0, 16'h0000, 8'h00, 8'd0, 0, 1, 0, 16'h1234, 8'h41, 1, 4'd0, 1);
        tv[4]  = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h41, 1, 4'd0, 1);
        tv[5]  = mk(0, 16'h0000, 8'h00, 8'd0, 0, 1, 0, 16'h1234, 8'h41, 1, 4'd0, 1);
        tv[6]  = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h40, 1, 4'd0, 1);
        tv[7]  = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h40, 1, 4'd0, 1);
        tv[8]  = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h40, 1, 4'd0, 1);
        tv[9]  = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h40, 1, 4'd0, 1);
        tv[10] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h40, 0, 4'd0, 1);
        tv[11] = mk(1, 16'hBEEF, 8'h21, 8'd1, 1, 1, 0, 16'h1234, 8'h40, 0, 4'd1, 1);
        tv[12] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'h1234, 8'h40, 1, 4'd1, 1);
        tv[13] = mk(1, 16'h0777, 8'h10, 8'd1, 1, 1, 0, 16'hBEEF, 8'h21, 1, 4'd1, 1);
        tv[14] = mk(0, 16'h0000, 8'h00, 8'd0, 0, 1, 0, 16'hBEEF, 8'h21, 1, 4'd1, 1);
        tv[15] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'hBEEF, 8'h20, 1, 4'd1, 1);
        tv[16] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'hBEEF, 8'h20, 1, 4'd1, 1);
        tv[17] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'hBEEF, 8'h20, 1, 4'd1, 1);
        tv[18] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'hBEEF, 8'h20, 1, 4'd1, 1);
        tv[19] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 1, 0, 16'hBEEF, 8'h20, 1, 4'd1, 1);
        tv[20] = mk(0, 16'h0000, 8'h00, 8'd0, 0, 1, 0, 16'h0777, 8'h11, 1, 4'd0, 1);
        tv[21] = mk(0, 16'h0000, 8'h00, 8'd0, 1, 0, 0, 16'h0777, 8'h10, 1, 4'd0, 1);
        tv[22] = mk(1, 16'h5555, 8'h30, 8'd3, 0, 1, 1, 16'h0777, 8'h10, 0, 4'd0, 1);

        do_reset();
        check("rst_freq", 0, o_frequency, 16'h0);
        check("rst_wave", 0, o_waveform, 8'h0);
        check("rst_busy", 0, o_busy, 0);
        check("rst_level", 0, o_level, 0);
        check("rst_ready", 0, o_push_ready, 1);

        foreach (tv[i]) begin
            i_push_valid = tv[i].pv;
            i_push_freq  = tv[i].pf;
            i_push_wave  = tv[i].pw;
            i_push_dur   = tv[i].pd;
            i_tick       = tv[i].tk;
            i_enable     = tv[i].en;
            i_flush      = tv[i].fl;
            step();
            check("tv_freq", i, o_frequency, tv[i].ef);
            check("tv_wave", i, o_waveform, tv[i].ew);
            check("tv_busy", i, o_busy, tv[i].eb);
            check("tv_level", i, o_level, tv[i].el);
            check("tv_ready", i, o_push_ready, tv[i].er);
        end
        {i_push_valid, i_flush, i_tick} = '0;

        // Single note with a tick every 16 cycles.
        do_reset();
        i_enable = 1'b1;
        auto_tick = 1;
        push(16'h1234, 8'h40, 8'd3);
        check("a_level", 0, o_level, 1);
        step();
        check("a_busy_load", 0, o_busy, 1);
        step();
        check("a_freq", 0, o_frequency, 16'h1234);
        check("a_wave", 0, o_waveform, 8'h41);
        measure(400, 0, g, r);
        check("a_gate_ticks", 0, g, 3);
        check("a_rel_ticks", 0, r, 4);
        check("a_idle_busy", 0, o_busy, 0);
        check("a_idle_wave", 0, o_waveform, 8'h40);
        check("a_idle_freq", 0, o_frequency, 16'h1234);

        // Fill the FIFO while disabled, then play in order.
        do_reset();
        for (int j = 0; j < 8; j++)
            push(16'h0100 * 16'(j + 1), 8'h20, 8'd1);
        check("b_level_full", 0, o_level, 8);
        check("b_ready_full", 0, o_push_ready, 0);
        push(16'hDEAD, 8'h20, 8'd1);
        check("b_level_ninth", 0, o_level, 8);
        i_enable = 1'b1;
        i_tick = 1'b1;
        k = 0;
        for (int c = 0; c < 500 && !(k == 8 && !o_busy); c++) begin
            pg = o_waveform[0];
            step();
            if (!pg && o_waveform[0]) begin
                check("b_order", k, o_frequency, 16'h0100 * 16'(k + 1));
                check("b_level_pop", k, o_level, 7 - k);
                k++;
            end
        end
        check("b_notes_played", 0, k, 8);
        check("b_end_busy", 0, o_busy, 0);

        // Duration 0 means 256 ticks.
        do_reset();
        i_enable = 1'b1;
        i_tick = 1'b1;
        push(16'h0ABC, 8'h10, 8'd0);
        measure(400, 1, g, r);
        check("c_gate_ticks", 0, g, 256);
        check("c_rel_ticks", 0, r, 4);

        // Flush mid-gate with 3 entries waiting; a same-cycle push is dropped.
        do_reset();
        for (int j = 0; j < 4; j++)
            push(16'h3000 + 16'(j), 8'h20, 8'd10);
        i_enable = 1'b1;
        wait_gate(1);
        check("d_level_before", 0, o_level, 3);
        i_flush = 1'b1;
        push(16'h5555, 8'h80, 8'd1);
        i_flush = 1'b0;
        check("d_gate", 0, o_waveform, 8'h20);
        check("d_level", 0, o_level, 0);
        check("d_busy", 0, o_busy, 0);
        check("d_freq", 0, o_frequency, 16'h3000);
        step();
        check("d_level_after", 0, o_level, 0);
        check("d_busy_after", 0, o_busy, 0);

        // Dropping enable mid-gate completes the note and keeps the queue.
        do_reset();
        for (int j = 0; j < 3; j++)
            push(16'h4000 + 16'(j), 8'h10, 8'd5);
        i_enable = 1'b1;
        wait_gate(2);
        check("e_level_before", 0, o_level, 2);
        i_enable = 1'b0;
        i_tick = 1'b1;
        measure(100, 2, g, r);
        check("e_gate_ticks", 0, g, 5);
        check("e_rel_ticks", 0, r, 4);
        check("e_busy", 0, o_busy, 0);
        check("e_level", 0, o_level, 2);
        check("e_freq", 0, o_frequency, 16'h4000);

`ifdef SID_NOTE_REST_EN
        do_reset();
        push(16'h1000, 8'h40, 8'd2);
        push(16'h0000, 8'h20, 8'd2);
        push(16'h2000, 8'h10, 8'd2);
        i_enable = 1'b1;
        i_tick = 1'b1;
        rises = 0;
        viol = 0;
        gap = 0;
        for (int c = 0; c < 100 && !(rises > 0 && !o_busy); c++) begin
            pg = o_waveform[0];
            step();
            if (o_busy && o_frequency == 16'h0)
                viol++;
            if (rises == 1 && !o_waveform[0])
                gap++;
            if (!pg && o_waveform[0]) begin
                if (rises < 2)
                    rf[rises] = o_frequency;
                rises++;
            end
        end
        check("f_rises", 0, rises, 2);
        check("f_first", 0, rf[0], 16'h1000);
        check("f_second", 0, rf[1], 16'h2000);
        check("f_freq_zero", 0, viol, 0);
        check("f_gap", 0, gap, 12);
`else
        do_reset();
        i_enable = 1'b1;
        push(16'h0000, 8'h40, 8'd1);
        step();
        step();
        check("f_zero_freq", 0, o_frequency, 16'h0);
        check("f_zero_wave", 0, o_waveform, 8'h41);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
